peripheral_timer_core: RTL and testbench
========================================

Name: peripheral_timer_core

Overview:
Multi-channel successor of the single-counter peripheral core: NUM_CH independent up/down counters of CNT_W bits, each with a compare register, periodic/one-shot mode and a sticky match interrupt. A shared prescaler generates the count tick. All register access is through a channel-select write port, and status is exported as flattened per-channel vectors. It sits behind the peripheral register interface, and its irq_out feeds the system interrupt controller.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
CNT_W, 32, counter/compare width in bits (8..64)
PRE_W, 8, prescaler width; tick period = prescale+1 clocks
CH_W, $clog2(NUM_CH) (min 1), derived select width; not overridden

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
ch_sel  in  CH_W  channel targeted by count_we/cmp_we/cfg_we
count_we  in  1  load count_in into selected channel counter
count_in  in  CNT_W  counter load value
cmp_we  in  1  load cmp_in into selected channel compare reg
cmp_in  in  CNT_W  compare load value
cfg_we  in  1  load en/dir/mode/ire of selected channel
en_in, dir_in, mode_in, ire_in  in  1 each  enable; 1=up/0=down; 1=one-shot/0=periodic; irq enable
pre_we  in  1  load prescale register
pre_in  in  PRE_W  prescale value
irq_clr  in  NUM_CH  per-channel pending clear pulse (W1C strobe)
count_out  out  NUM_CH*CNT_W  counters, ch0 in LSBs
cmp_out  out  NUM_CH*CNT_W  compare regs
cfg_out  out  NUM_CH*4  {ire,mode,dir,en} per channel, ch0 in LSBs
pend_out  out  NUM_CH  sticky match flags
irq_out  out  1  registered OR of (pend & ire)

Behaviour:
- Reset (async, reset_n low): all counters, compares, cfg bits, prescaler, pending, irq_out = 0. Release is synchronous to clk.
- Prescaler: pre_cnt increments each clock. When pre_cnt == prescale: tick = 1 and pre_cnt <= 0. pre_we loads prescale and clears pre_cnt. prescale = 0 gives a tick every clock.
- Per channel on tick with en = 1:
  - Up: if count == cmp then match; else count + 1.
  - Down: if count == 0 then match; else count - 1.
- On match:
  - pend <= 1.
  - Periodic: up reloads 0, down reloads cmp.
  - One-shot: count holds, en <= 0.
- Arithmetic is modulo 2^CNT_W. Up with cmp below count wraps through max to 0 before matching.
- Write priority per channel:
  - count_we beats tick update (no match evaluated that cycle).
  - cfg_we beats one-shot auto-clear of en.
  - Match set beats same-cycle irq_clr (pend stays 1).
  - ch_sel >= NUM_CH: writes ignored.
- cmp_we takes effect for the next tick's comparison.
- irq_out = |(pend & ire), registered: asserted 1 clock after pend sets. ire = 0 masks irq_out but not pend.
- Writes issued concurrently to count_we, cmp_we and cfg_we all target ch_sel and are all applied.

Optional Feature:
TIMER_CAPTURE_EN:
- Defined:
  - Adds ports cap_in (in, NUM_CH), cap_out (out, NUM_CH*CNT_W) and cap_flag_out (out, NUM_CH).
  - cap_in is double-flop synchronised. A rising edge latches the current count into cap and sets cap_flag.
  - cap_flag clears on irq_clr of that channel unless a new edge arrives the same cycle.
  - cap_flag also ORs into irq_out when ire = 1.
- Undefined: ports absent, no capture logic.

Test Plan:
- Reset mid-count: ch0 counting, reset_n low asynchronously between clock edges -> all outputs 0 immediately, irq_out 0.
- Periodic up: prescale = 0, ch0 cmp = 5, up, periodic, ire = 1 -> count 0,1,..,5,0; pend[0] set on the cycle after count = 5; irq_out high one clock later; irq_clr[0] drops both.
- One-shot down, prescale = 3: ch1 count = 3 -> count decrements every 4 clocks to 0; en[1] clears; count holds 0; pend[1] = 1.
- Collisions: count_we to ch2 on its match tick -> count = count_in, pend unchanged. irq_clr on a match cycle -> pend stays 1.
- Wrap: CNT_W = 8, up, count = 250, cmp = 3 -> 255, 0, 1, 2, 3 then match.
- TIMER_CAPTURE_EN: cap_in[0] rises while count = 0x10 -> cap_out[0] = 0x10 or 0x11 (sync latency), cap_flag_out[0] = 1.

Source files
------------

// File: rtl/peripheral_timer_core_if.sv
// Register write port and status bus of peripheral_timer_core.
// Capture signals exist only when TIMER_CAPTURE_EN is defined.
interface peripheral_timer_core_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [CH_W-1:0]         ch_sel;
    logic                    count_we;
    logic [CNT_W-1:0]        count_in;
    logic                    cmp_we;
    logic [CNT_W-1:0]        cmp_in;
    logic                    cfg_we;
    logic                    en_in;
    logic                    dir_in;
    logic                    mode_in;
    logic                    ire_in;
    logic                    pre_we;
    logic [PRE_W-1:0]        pre_in;
    logic [NUM_CH-1:0]       irq_clr;
    logic [NUM_CH*CNT_W-1:0] count_out;
    logic [NUM_CH*CNT_W-1:0] cmp_out;
    logic [NUM_CH*4-1:0]     cfg_out;
    logic [NUM_CH-1:0]       pend_out;
    logic                    irq_out;
`ifdef TIMER_CAPTURE_EN
    logic [NUM_CH-1:0]       cap_in;
    logic [NUM_CH*CNT_W-1:0] cap_out;
    logic [NUM_CH-1:0]       cap_flag_out;
`endif

    modport master (
        output ch_sel, count_we, count_in, cmp_we, cmp_in, cfg_we,
               en_in, dir_in, mode_in, ire_in, pre_we, pre_in, irq_clr,
`ifdef TIMER_CAPTURE_EN
        output cap_in,
        input  cap_out, cap_flag_out,
`endif
        input  count_out, cmp_out, cfg_out, pend_out, irq_out
    );

    modport slave (
        input  ch_sel, count_we, count_in, cmp_we, cmp_in, cfg_we,
               en_in, dir_in, mode_in, ire_in, pre_we, pre_in, irq_clr,
`ifdef TIMER_CAPTURE_EN
        input  cap_in,
        output cap_out, cap_flag_out,
`endif
        output count_out, cmp_out, cfg_out, pend_out, irq_out
    );
endinterface

// File: rtl/peripheral_timer_core.sv
// Multi-channel up/down timer with shared prescaler, compare match and sticky irq.
// Optional input capture per channel is enabled by defining TIMER_CAPTURE_EN.
module peripheral_timer_core #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8
) (
    input logic clk,
    input logic reset_n,
    peripheral_timer_core_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PRE_W-1:0]  prescale;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [CNT_W-1:0]  count [NUM_CH];
    logic [CNT_W-1:0]  cmp   [NUM_CH];
    logic [NUM_CH-1:0] en, dir, mode, ire, pend;
    logic [NUM_CH-1:0] sel, load, match;
    logic              irq;
    logic              irq_src;

    // Reload/step value for a ticking channel; a match in periodic mode restarts the period.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] cmpv,
        input logic             up,
        input logic             oneshot,
        input logic             hit
    );
        if (hit)
            next_count = oneshot ? cur : (up ? '0 : cmpv);
        else
            next_count = up ? cur + CNT_W'(1) : cur - CNT_W'(1);
    endfunction

    assign tick = (pre_cnt == prescale);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else if (bus.pre_we) begin
            prescale <= bus.pre_in;
            pre_cnt  <= '0;
        end else begin
            pre_cnt  <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // A counter load in the same cycle suppresses match evaluation for that channel.
    always_comb begin
        sel   = '0;
        load  = '0;
        match = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i]   = (bus.ch_sel == CH_W'(i));
            load[i]  = bus.count_we & sel[i];
            match[i] = tick & en[i] & ~load[i] &
                       (dir[i] ? (count[i] == cmp[i]) : (count[i] == '0));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i] <= '0;
                cmp[i]   <= '0;
            end
            en   <= '0;
            dir  <= '0;
            mode <= '0;
            ire  <= '0;
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load[i])
                    count[i] <= bus.count_in;
                else if (tick && en[i])
                    count[i] <= next_count(count[i], cmp[i], dir[i], mode[i], match[i]);

                if (bus.cmp_we && sel[i])
                    cmp[i] <= bus.cmp_in;

                if (bus.cfg_we && sel[i]) begin
                    en[i]   <= bus.en_in;
                    dir[i]  <= bus.dir_in;
                    mode[i] <= bus.mode_in;
                    ire[i]  <= bus.ire_in;
                end else if (match[i] && mode[i]) begin
                    en[i]   <= 1'b0;
                end

                if (match[i])
                    pend[i] <= 1'b1;
                else if (bus.irq_clr[i])
                    pend[i] <= 1'b0;
            end
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [NUM_CH-1:0] cap_s1, cap_s2, cap_s3, cap_rise, cap_flag;
    logic [CNT_W-1:0]  cap [NUM_CH];

    assign cap_rise = cap_s2 & ~cap_s3;

    // Two flops resynchronise cap_in; the third holds the previous level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_s1   <= '0;
            cap_s2   <= '0;
            cap_s3   <= '0;
            cap_flag <= '0;
            for (int i = 0; i < NUM_CH; i++)
                cap[i] <= '0;
        end else begin
            cap_s1 <= bus.cap_in;
            cap_s2 <= cap_s1;
            cap_s3 <= cap_s2;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap_rise[i]) begin
                    cap[i]      <= count[i];
                    cap_flag[i] <= 1'b1;
                end else if (bus.irq_clr[i]) begin
                    cap_flag[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.cap_out = '0;
        for (int i = 0; i < NUM_CH; i++)
            bus.cap_out[i*CNT_W +: CNT_W] = cap[i];
    end

    assign bus.cap_flag_out = cap_flag;
    assign irq_src = |((pend | cap_flag) & ire);
`else
    assign irq_src = |(pend & ire);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= irq_src;
    end

    always_comb begin
        bus.count_out = '0;
        bus.cmp_out   = '0;
        bus.cfg_out   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.count_out[i*CNT_W +: CNT_W] = count[i];
            bus.cmp_out[i*CNT_W +: CNT_W]   = cmp[i];
            bus.cfg_out[i*4 +: 4]           = {ire[i], mode[i], dir[i], en[i]};
        end
    end

    assign bus.pend_out = pend;
    assign bus.irq_out  = irq;
endmodule

// File: tb/tb_peripheral_timer_core.sv
// Scoreboard bench for peripheral_timer_core: randomized and directed register traffic
// checked against a cycle-level behavioural model (TIMER_CAPTURE_EN optional).
module tb_peripheral_timer_core;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int PRE_W  = 4;
    localparam int CH_W   = 2;
    localparam int CMAX   = 1 << CNT_W;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    peripheral_timer_core_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

    peripheral_timer_core #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [NUM_CH*CNT_W-1:0] count;
        logic [NUM_CH*CNT_W-1:0] cmp;
        logic [NUM_CH*4-1:0]     cfg;
        logic [NUM_CH-1:0]       pend;
        logic                    irq;
`ifdef TIMER_CAPTURE_EN
        logic [NUM_CH*CNT_W-1:0] cap;
        logic [NUM_CH-1:0]       cflag;
`endif
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    int m_count [NUM_CH];
    int m_cmp   [NUM_CH];
    bit m_en [NUM_CH], m_dir [NUM_CH], m_mode [NUM_CH], m_ire [NUM_CH], m_pend [NUM_CH];
    int m_pre, m_scale;
    bit m_irq;
    bit m_s1 [NUM_CH], m_s2 [NUM_CH], m_s3 [NUM_CH], m_cflag [NUM_CH];
    int m_cap [NUM_CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_count[c] = 0; m_cmp[c] = 0; m_cap[c] = 0;
            m_en[c] = 0; m_dir[c] = 0; m_mode[c] = 0; m_ire[c] = 0; m_pend[c] = 0;
            m_s1[c] = 0; m_s2[c] = 0; m_s3[c] = 0; m_cflag[c] = 0;
        end
        m_pre = 0; m_scale = 0; m_irq = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs currently driven.
    task automatic model_step();
        bit tick, irq_next, hit, mt, rise;
        int old_count;
        tick = (m_pre == m_scale);
        irq_next = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_ire[c] && m_pend[c]) irq_next = 1;
`ifdef TIMER_CAPTURE_EN
            if (m_ire[c] && m_cflag[c]) irq_next = 1;
`endif
        end
        for (int c = 0; c < NUM_CH; c++) begin
            hit = (int'(bus.ch_sel) == c);
            mt = 0;
            old_count = m_count[c];
            if (bus.count_we && hit) begin
                m_count[c] = int'(bus.count_in);
            end else if (tick && m_en[c]) begin
                if (m_dir[c]) begin
                    if (m_count[c] == m_cmp[c]) mt = 1;
                    else m_count[c] = (m_count[c] + 1) % CMAX;
                end else begin
                    if (m_count[c] == 0) mt = 1;
                    else m_count[c] = m_count[c] - 1;
                end
                if (mt && !m_mode[c]) m_count[c] = m_dir[c] ? 0 : m_cmp[c];
            end
            if (mt) m_pend[c] = 1;
            else if (bus.irq_clr[c]) m_pend[c] = 0;
            if (bus.cfg_we && hit) begin
                m_en[c] = bus.en_in; m_dir[c] = bus.dir_in;
                m_mode[c] = bus.mode_in; m_ire[c] = bus.ire_in;
            end else if (mt && m_mode[c]) begin
                m_en[c] = 0;
            end
            if (bus.cmp_we && hit) m_cmp[c] = int'(bus.cmp_in);
`ifdef TIMER_CAPTURE_EN
            rise = m_s2[c] && !m_s3[c];
            if (rise) begin
                m_cap[c] = old_count;
                m_cflag[c] = 1;
            end else if (bus.irq_clr[c]) begin
                m_cflag[c] = 0;
            end
            m_s3[c] = m_s2[c]; m_s2[c] = m_s1[c]; m_s1[c] = bus.cap_in[c];
`else
            rise = 0;
            if (rise) m_cap[c] = old_count;
`endif
        end
        if (bus.pre_we) begin
            m_scale = int'(bus.pre_in);
            m_pre = 0;
        end else begin
            m_pre = tick ? 0 : m_pre + 1;
        end
        m_irq = irq_next;
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            e.count[c*CNT_W +: CNT_W] = CNT_W'(m_count[c]);
            e.cmp[c*CNT_W +: CNT_W]   = CNT_W'(m_cmp[c]);
            e.cfg[c*4 +: 4]           = {m_ire[c], m_mode[c], m_dir[c], m_en[c]};
            e.pend[c]                 = m_pend[c];
`ifdef TIMER_CAPTURE_EN
            e.cap[c*CNT_W +: CNT_W]   = CNT_W'(m_cap[c]);
            e.cflag[c]                = m_cflag[c];
`endif
        end
        e.irq = m_irq;
        return e;
    endfunction

    task automatic idle();
        bus.ch_sel = '0; bus.count_we = 0; bus.count_in = '0; bus.cmp_we = 0; bus.cmp_in = '0;
        bus.cfg_we = 0; bus.en_in = 0; bus.dir_in = 0; bus.mode_in = 0; bus.ire_in = 0;
        bus.pre_we = 0; bus.pre_in = '0; bus.irq_clr = '0;
    endtask

    // Called at a falling edge with inputs set: predict the next edge, then move on.
    task automatic do_cycle();
        model_step();
        exp_q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic run_idle(input int n);
        idle();
        for (int k = 0; k < n; k++) do_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, 64'(bus.count_out), 64'(0));
        check({tag, "_cmp"},   64'(bus.cmp_out),   64'(0));
        check({tag, "_cfg"},   64'(bus.cfg_out),   64'(0));
        check({tag, "_pend"},  64'(bus.pend_out),  64'(0));
        check({tag, "_irq"},   64'(bus.irq_out),   64'(0));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count_out", 64'(bus.count_out), 64'(e.count));
                check("cmp_out",   64'(bus.cmp_out),   64'(e.cmp));
                check("cfg_out",   64'(bus.cfg_out),   64'(e.cfg));
                check("pend_out",  64'(bus.pend_out),  64'(e.pend));
                check("irq_out",   64'(bus.irq_out),   64'(e.irq));
`ifdef TIMER_CAPTURE_EN
                check("cap_out",      64'(bus.cap_out),      64'(e.cap));
                check("cap_flag_out", 64'(bus.cap_flag_out), 64'(e.cflag));
`endif
            end
        end
    end

    initial begin : driver
        idle();
`ifdef TIMER_CAPTURE_EN
        bus.cap_in = '0;
`endif
        model_reset();
        #1 reset_n = 0;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        // Periodic up on ch0, all three writes in one cycle, tick every clock
        bus.pre_we = 1; bus.pre_in = '0;
        bus.ch_sel = 2'd0; bus.cmp_we = 1; bus.cmp_in = 8'd5;
        bus.cfg_we = 1; bus.en_in = 1; bus.dir_in = 1; bus.mode_in = 0; bus.ire_in = 1;
        do_cycle();
        run_idle(9);
        bus.irq_clr = 3'b001;
        do_cycle();
        run_idle(3);
        // Stop ch0, then one-shot down on ch1 with prescale 3
        bus.ch_sel = 2'd0; bus.cfg_we = 1; bus.en_in = 0;
        do_cycle();
        bus.pre_we = 1; bus.pre_in = 4'd3;
        bus.ch_sel = 2'd1; bus.count_we = 1; bus.count_in = 8'd3;
        bus.cfg_we = 1; bus.en_in = 1; bus.dir_in = 0; bus.mode_in = 1; bus.ire_in = 0;
        do_cycle();
        run_idle(20);
        // Wrap on ch2: 250 up to cmp 3 through 255
        bus.pre_we = 1; bus.pre_in = '0;
        bus.ch_sel = 2'd2; bus.count_we = 1; bus.count_in = 8'd250;
        bus.cmp_we = 1; bus.cmp_in = 8'd3;
        bus.cfg_we = 1; bus.en_in = 1; bus.dir_in = 1; bus.mode_in = 0; bus.ire_in = 1;
        do_cycle();
        run_idle(9);
        // Load ch2 while it sits on its compare value, and clear pend on a match cycle of ch2
        bus.ch_sel = 2'd2; bus.count_we = 1; bus.count_in = 8'd3;
        do_cycle();
        bus.count_we = 1; bus.count_in = 8'd7;
        do_cycle();
        bus.count_we = 1; bus.count_in = 8'd3;
        do_cycle();
        bus.irq_clr = 3'b100;
        do_cycle();
        // Out-of-range channel select
        bus.ch_sel = 2'd3; bus.count_we = 1; bus.count_in = 8'hAA;
        bus.cmp_we = 1; bus.cmp_in = 8'h55; bus.cfg_we = 1; bus.en_in = 1; bus.ire_in = 1;
        do_cycle();
        run_idle(3);

        // Asynchronous reset between edges while counting
        idle();
        #2 reset_n = 0;
        #1 check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        reset_n = 1;

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            idle();
            bus.ch_sel   = CH_W'($urandom_range(0, 3));
            bus.count_we = ($urandom_range(0, 15) == 0);
            bus.count_in = $urandom_range(0, 1) ? CNT_W'($urandom_range(0, 8))
                                                : CNT_W'($urandom_range(0, 255));
            bus.cmp_we   = ($urandom_range(0, 15) == 0);
            bus.cmp_in   = CNT_W'($urandom_range(0, 10));
            bus.cfg_we   = ($urandom_range(0, 11) == 0);
            bus.en_in    = ($urandom_range(0, 3) != 0);
            bus.dir_in   = 1'($urandom_range(0, 1));
            bus.mode_in  = 1'($urandom_range(0, 1));
            bus.ire_in   = 1'($urandom_range(0, 1));
            bus.pre_we   = ($urandom_range(0, 63) == 0);
            bus.pre_in   = PRE_W'($urandom_range(0, 3));
            for (int c = 0; c < NUM_CH; c++) bus.irq_clr[c] = ($urandom_range(0, 7) == 0);
`ifdef TIMER_CAPTURE_EN
            if ($urandom_range(0, 5) == 0) bus.cap_in = bus.cap_in ^ NUM_CH'($urandom_range(1, 7));
`endif
            do_cycle();
        end
        idle();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
